// File: rtl/fft_bitrev_pingpong_buffer.sv
// Ping-pong reorder buffer in front of the radix-2 FFT core: stores each N-sample frame
// at bit-reversed (or natural) addresses and replays it in address order on a registered stream.
module fft_bitrev_pingpong_buffer #(
  parameter int N      = 16,
  parameter int DATA_W = 32,
  localparam int AW    = $clog2(N)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush_i,
  input  logic              bitrev_i,
  input  logic [DATA_W-1:0] s_re_i,
  input  logic [DATA_W-1:0] s_im_i,
  input  logic              s_valid_i,
  input  logic              s_last_i,
  output logic              s_ready_o,
  output logic [DATA_W-1:0] m_re_o,
  output logic [DATA_W-1:0] m_im_o,
  output logic              m_valid_o,
  input  logic              m_ready_i,
  output logic              m_last_o,
  output logic [AW-1:0]     m_index_o,
  output logic              err_o
);

  function automatic logic [AW-1:0] bitrev(input logic [AW-1:0] a);
    logic [AW-1:0] r;
    r = '0;
    for (int i = 0; i < AW; i++) begin
      r[i] = a[AW-1-i];
    end
    return r;
  endfunction

  logic [2*DATA_W-1:0] bank0_q [N];
  logic [2*DATA_W-1:0] bank1_q [N];

  logic              wr_bank_q, wr_bank_d;
  logic              rd_bank_q, rd_bank_d;
  logic [1:0]        full_q, full_d;
  logic [AW-1:0]     wcnt_q, wcnt_d;
  logic [AW-1:0]     rcnt_q, rcnt_d;
  logic              mode_q, mode_d;
  logic              s_ready_q, s_ready_d;
  logic [DATA_W-1:0] m_re_q, m_re_d;
  logic [DATA_W-1:0] m_im_q, m_im_d;
  logic              m_valid_q, m_valid_d;
  logic              m_last_q, m_last_d;
  logic [AW-1:0]     m_index_q, m_index_d;
  logic              err_q, err_d;

  logic                s_hs;
  logic                wr_en;
  logic                wr_mode;
  logic                wr_last;
  logic [AW-1:0]       wr_addr;
  logic                rd_load;
  logic                rd_last;
  logic [2*DATA_W-1:0] rd_word;

  assign s_hs    = s_valid_i & s_ready_q;
  assign wr_en   = s_hs & ~flush_i;
  // The mode is sampled live on the first word and taken from the latch afterwards.
  assign wr_mode = (wcnt_q == '0) ? bitrev_i : mode_q;
  assign wr_last = (wcnt_q == AW'(N-1));
  assign wr_addr = wr_mode ? bitrev(wcnt_q) : wcnt_q;
  assign rd_load = full_q[rd_bank_q] & (~m_valid_q | m_ready_i);
  assign rd_last = (rcnt_q == AW'(N-1));
  assign rd_word = rd_bank_q ? bank1_q[rcnt_q] : bank0_q[rcnt_q];

  // Sample storage; contents are don't-care until a bank is marked full.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      if (wr_bank_q) begin
        bank1_q[wr_addr] <= {s_re_i, s_im_i};
      end else begin
        bank0_q[wr_addr] <= {s_re_i, s_im_i};
      end
    end
  end

  // Next-state logic for both write and read sides.
  always_comb begin
    wr_bank_d = wr_bank_q;
    rd_bank_d = rd_bank_q;
    full_d    = full_q;
    wcnt_d    = wcnt_q;
    rcnt_d    = rcnt_q;
    mode_d    = mode_q;
    m_re_d    = m_re_q;
    m_im_d    = m_im_q;
    m_valid_d = m_valid_q;
    m_last_d  = m_last_q;
    m_index_d = m_index_q;
    err_d     = 1'b0;
    s_ready_d = s_ready_q;
    if (flush_i) begin
      wr_bank_d = 1'b0;
      rd_bank_d = 1'b0;
      full_d    = 2'b00;
      wcnt_d    = '0;
      rcnt_d    = '0;
      mode_d    = 1'b0;
      m_re_d    = '0;
      m_im_d    = '0;
      m_valid_d = 1'b0;
      m_last_d  = 1'b0;
      m_index_d = '0;
      s_ready_d = 1'b0;
    end else begin
      if (s_hs) begin
        mode_d = wr_mode;
        err_d  = s_last_i ^ wr_last;
        if (wr_last) begin
          wcnt_d            = '0;
          full_d[wr_bank_q] = 1'b1;
          wr_bank_d         = ~wr_bank_q;
        end else begin
          wcnt_d = wcnt_q + AW'(1);
        end
      end else begin
        err_d = 1'b0;
      end
      if (rd_load) begin
        m_re_d    = rd_word[2*DATA_W-1:DATA_W];
        m_im_d    = rd_word[DATA_W-1:0];
        m_valid_d = 1'b1;
        m_index_d = rcnt_q;
        m_last_d  = rd_last;
        if (rd_last) begin
          rcnt_d            = '0;
          full_d[rd_bank_q] = 1'b0;
          rd_bank_d         = ~rd_bank_q;
        end else begin
          rcnt_d = rcnt_q + AW'(1);
        end
      end else if (m_ready_i) begin
        m_valid_d = 1'b0;
      end else begin
        m_valid_d = m_valid_q;
      end
      // Ready looks ahead at the post-edge bank state so it never lags a freed bank.
      s_ready_d = ~full_d[wr_bank_d];
    end
  end

  // Control and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_bank_q <= 1'b0;
      rd_bank_q <= 1'b0;
      full_q    <= 2'b00;
      wcnt_q    <= '0;
      rcnt_q    <= '0;
      mode_q    <= 1'b0;
      s_ready_q <= 1'b0;
      m_re_q    <= '0;
      m_im_q    <= '0;
      m_valid_q <= 1'b0;
      m_last_q  <= 1'b0;
      m_index_q <= '0;
      err_q     <= 1'b0;
    end else begin
      wr_bank_q <= wr_bank_d;
      rd_bank_q <= rd_bank_d;
      full_q    <= full_d;
      wcnt_q    <= wcnt_d;
      rcnt_q    <= rcnt_d;
      mode_q    <= mode_d;
      s_ready_q <= s_ready_d;
      m_re_q    <= m_re_d;
      m_im_q    <= m_im_d;
      m_valid_q <= m_valid_d;
      m_last_q  <= m_last_d;
      m_index_q <= m_index_d;
      err_q     <= err_d;
    end
  end

  assign s_ready_o = s_ready_q;
  assign m_re_o    = m_re_q;
  assign m_im_o    = m_im_q;
  assign m_valid_o = m_valid_q;
  assign m_last_o  = m_last_q;
  assign m_index_o = m_index_q;
  assign err_o     = err_q;

endmodule

// File: tb/tb_fft_bitrev_pingpong_buffer.sv
// Directed bench for the ping-pong bit-reversal buffer (N=16, DATA_W=32).
module tb_fft_bitrev_pingpong_buffer;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush_i;
  logic        bitrev_i;
  logic [31:0] s_re_i;
  logic [31:0] s_im_i;
  logic        s_valid_i;
  logic        s_last_i;
  logic        s_ready_o;
  logic [31:0] m_re_o;
  logic [31:0] m_im_o;
  logic        m_valid_o;
  logic        m_ready_i;
  logic        m_last_o;
  logic [3:0]  m_index_o;
  logic        err_o;

  fft_bitrev_pingpong_buffer #(.N(16), .DATA_W(32)) dut (
    .clk(clk), .rst(rst), .flush_i(flush_i), .bitrev_i(bitrev_i),
    .s_re_i(s_re_i), .s_im_i(s_im_i), .s_valid_i(s_valid_i), .s_last_i(s_last_i),
    .s_ready_o(s_ready_o), .m_re_o(m_re_o), .m_im_o(m_im_o), .m_valid_o(m_valid_o),
    .m_ready_i(m_ready_i), .m_last_o(m_last_o), .m_index_o(m_index_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int err_cnt = 0;
  int stall_cnt = 0;
  int last_in_cyc = 0;
  int br[16] = '{0, 8, 4, 12, 2, 10, 6, 14, 1, 9, 5, 13, 3, 11, 7, 15};

  logic [31:0] q_re[$];
  logic [31:0] q_im[$];
  logic [3:0]  q_idx[$];
  logic        q_last[$];
  int          q_cyc[$];

  always @(posedge clk) cyc <= cyc + 1;

  // Records accepted output samples and event counts away from the active edge.
  always @(negedge clk) begin
    if (m_valid_o && m_ready_i) begin
      q_re.push_back(m_re_o);
      q_im.push_back(m_im_o);
      q_idx.push_back(m_index_o);
      q_last.push_back(m_last_o);
      q_cyc.push_back(cyc);
    end
    if (err_o) err_cnt <= err_cnt + 1;
    if (s_valid_i && !s_ready_o) stall_cnt <= stall_cnt + 1;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_frame(input int base, input bit mode, input bit im_on,
                            input int la, input int lb, input int nsamp);
    for (int k = 0; k < nsamp; k++) begin
      int t;
      s_valid_i = 1'b1;
      s_re_i    = 32'(base + k);
      s_im_i    = im_on ? (32'hA000_0000 + 32'(base + k)) : 32'h0;
      bitrev_i  = mode;
      s_last_i  = (k == la) || (k == lb);
      t = 0;
      @(negedge clk);
      while (!s_ready_o && t < 200) begin
        t++;
        @(negedge clk);
      end
      chk("in_handshake_ready", {63'b0, s_ready_o}, 64'd1);
      @(posedge clk);
      #1;
    end
    s_valid_i   = 1'b0;
    s_last_i    = 1'b0;
    last_in_cyc = cyc;
  endtask

  task automatic wait_out(input int target);
    int t;
    t = 0;
    while (q_re.size() < target && t < 2000) begin
      @(posedge clk);
      t++;
    end
    repeat (3) @(posedge clk);
    #1;
    chk("out_count", 64'(q_re.size()), 64'(target));
  endtask

  task automatic check_frame(input int off, input int base, input bit mode, input bit im_on);
    if (q_re.size() >= off + 16) begin
      for (int k = 0; k < 16; k++) begin
        int ki;
        ki = mode ? br[k] : k;
        chk("m_re", 64'(q_re[off+k]), 64'(32'(base + ki)));
        chk("m_im", 64'(q_im[off+k]),
            im_on ? 64'(32'hA000_0000 + 32'(base + ki)) : 64'd0);
        chk("m_index", 64'(q_idx[off+k]), 64'(k));
        chk("m_last", 64'(q_last[off+k]), (k == 15) ? 64'd1 : 64'd0);
      end
    end else begin
      chk("frame_present", 64'(q_re.size()), 64'(off + 16));
    end
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_s_ready"}, {63'b0, s_ready_o}, 64'd0);
    chk({tag, "_m_valid"}, {63'b0, m_valid_o}, 64'd0);
    chk({tag, "_m_re"}, 64'(m_re_o), 64'd0);
    chk({tag, "_m_im"}, 64'(m_im_o), 64'd0);
    chk({tag, "_m_last"}, {63'b0, m_last_o}, 64'd0);
    chk({tag, "_m_index"}, 64'(m_index_o), 64'd0);
    chk({tag, "_err"}, {63'b0, err_o}, 64'd0);
  endtask

  initial begin
    int off;
    int e0;
    rst = 1'b1; flush_i = 1'b0; bitrev_i = 1'b0; s_re_i = '0; s_im_i = '0;
    s_valid_i = 1'b0; s_last_i = 1'b0; m_ready_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_outputs_zero("reset");
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("ready_after_reset", {63'b0, s_ready_o}, 64'd1);

    // Case 1: bit-reversed store, latency from last input edge.
    m_ready_i = 1'b1;
    off = q_re.size(); e0 = err_cnt;
    send_frame(0, 1'b1, 1'b0, 15, -1, 16);
    wait_out(off + 16);
    check_frame(off, 0, 1'b1, 1'b0);
    if (q_cyc.size() > off) chk("latency", 64'(q_cyc[off] - last_in_cyc), 64'd1);
    chk("err_case1", 64'(err_cnt - e0), 64'd0);

    // Case 2: natural store.
    off = q_re.size(); e0 = err_cnt;
    send_frame(0, 1'b0, 1'b0, 15, -1, 16);
    wait_out(off + 16);
    check_frame(off, 0, 1'b0, 1'b0);
    chk("err_case2", 64'(err_cnt - e0), 64'd0);

    // Case 3: three back-to-back frames at full rate.
    off = q_re.size(); e0 = stall_cnt;
    send_frame(100, 1'b1, 1'b1, 15, -1, 16);
    send_frame(200, 1'b0, 1'b1, 15, -1, 16);
    send_frame(300, 1'b1, 1'b1, 15, -1, 16);
    wait_out(off + 48);
    chk("stream_stalls", 64'(stall_cnt - e0), 64'd0);
    if (q_cyc.size() >= off + 48) chk("stream_contiguous", 64'(q_cyc[off+47] - q_cyc[off]), 64'd47);
    check_frame(off, 100, 1'b1, 1'b1);
    check_frame(off + 16, 200, 1'b0, 1'b1);
    check_frame(off + 32, 300, 1'b1, 1'b1);

    // Case 4: backpressure with both banks full.
    m_ready_i = 1'b0;
    off = q_re.size();
    send_frame(400, 1'b0, 1'b1, 15, -1, 16);
    send_frame(500, 1'b1, 1'b1, 15, -1, 16);
    repeat (3) @(posedge clk);
    #1;
    chk("bp_ready_low", {63'b0, s_ready_o}, 64'd0);
    chk("bp_valid_high", {63'b0, m_valid_o}, 64'd1);
    chk("bp_hold_re", 64'(m_re_o), 64'd400);
    fork
      send_frame(600, 1'b0, 1'b1, 15, -1, 16);
      begin
        repeat (10) @(posedge clk);
        #1;
        chk("bp_still_stalled", {63'b0, s_ready_o}, 64'd0);
        chk("bp_hold_re2", 64'(m_re_o), 64'd400);
        chk("bp_hold_im", 64'(m_im_o), 64'(32'hA000_0000 + 32'd400));
        chk("bp_none_out", 64'(q_re.size()), 64'(off));
        m_ready_i = 1'b1;
      end
    join
    wait_out(off + 48);
    check_frame(off, 400, 1'b0, 1'b1);
    check_frame(off + 16, 500, 1'b1, 1'b1);
    check_frame(off + 32, 600, 1'b0, 1'b1);

    // Case 5: early end-of-frame marker.
    off = q_re.size(); e0 = err_cnt;
    send_frame(700, 1'b0, 1'b1, 8, 15, 16);
    wait_out(off + 16);
    chk("err_once", 64'(err_cnt - e0), 64'd1);
    check_frame(off, 700, 1'b0, 1'b1);

    // Case 6: asynchronous reset mid-frame with a held output.
    m_ready_i = 1'b0;
    send_frame(800, 1'b0, 1'b1, 15, -1, 16);
    repeat (3) @(posedge clk);
    #1;
    chk("pre_rst_valid", {63'b0, m_valid_o}, 64'd1);
    send_frame(900, 1'b0, 1'b1, -1, -1, 7);
    rst = 1'b1;
    #1;
    chk_outputs_zero("async_rst");
    @(posedge clk);
    #1;
    rst = 1'b0;
    m_ready_i = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    off = q_re.size();
    send_frame(0, 1'b1, 1'b0, 15, -1, 16);
    wait_out(off + 16);
    check_frame(off, 0, 1'b1, 1'b0);

    // Flush mid-frame, with a sample offered in the flush cycle.
    send_frame(50, 1'b1, 1'b1, -1, -1, 5);
    s_valid_i = 1'b1; s_re_i = 32'd99; flush_i = 1'b1;
    @(posedge clk);
    #1;
    flush_i = 1'b0; s_valid_i = 1'b0;
    chk("flush_ready", {63'b0, s_ready_o}, 64'd0);
    chk("flush_valid", {63'b0, m_valid_o}, 64'd0);
    off = q_re.size();
    send_frame(1000, 1'b0, 1'b1, 15, -1, 16);
    wait_out(off + 16);
    check_frame(off, 1000, 1'b0, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
